// File: rtl/regfile_write_arbiter_pkg.sv
// Shared types and constants for the register-file write arbiter.
// Optional conflict counter is enabled by defining REGWR_CONFLICT_CNT_EN.
package regfile_write_arbiter_pkg;

  typedef enum logic {
    PRIO0 = 1'b0,
    PRIO1 = 1'b1
  } prio_e;

  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

  function automatic logic is_zero_reg(input logic [REG_ADDR_W-1:0] addr);
    return addr == ZERO_REG;
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Two writeback requesters plus the registered register-file write port.
// master = requester/regfile side, slave = arbiter side.
interface regfile_write_arbiter_if #(
  parameter int N = 32
);
  import regfile_write_arbiter_pkg::*;

  logic                  req0_valid;
  logic [REG_ADDR_W-1:0] req0_addr;
  logic [N-1:0]          req0_data;
  logic                  req0_ready;

  logic                  req1_valid;
  logic [REG_ADDR_W-1:0] req1_addr;
  logic [N-1:0]          req1_data;
  logic                  req1_ready;

  logic                  RegWrite;
  logic [REG_ADDR_W-1:0] WriteRegister;
  logic [N-1:0]          WriteData;

  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    input  req0_ready, req1_ready,
    input  RegWrite, WriteRegister, WriteData
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    output req0_ready, req1_ready,
    output RegWrite, WriteRegister, WriteData
  );

endinterface

// File: rtl/regfile_write_arbiter_rr_arbiter2.sv
// 2-way round-robin grant with a two-state priority FSM.
// Grants are forced low while reset or hold is asserted.
module rr_arbiter2
  import regfile_write_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       hold_i,
  input  logic [1:0] valid_i,
  output logic [1:0] grant_o
);

  prio_e state_q, state_d;

  always_ff @(posedge clk) begin
    if (!reset) state_q <= PRIO0;
    else        state_q <= state_d;
  end

  always_comb begin
    grant_o = '0;
    state_d = state_q;
    if (reset && !hold_i) begin
      unique case (valid_i)
        2'b01:   grant_o = 2'b01;
        2'b10:   grant_o = 2'b10;
        2'b11:   grant_o = (state_q == PRIO0) ? 2'b01 : 2'b10;
        default: grant_o = '0;
      endcase
    end
    // Winner yields tie priority to the other requester.
    if (grant_o[0])      state_d = PRIO1;
    else if (grant_o[1]) state_d = PRIO0;
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Register-file write arbiter: output register, zero-register filter and
// optional conflict counter (REGWR_CONFLICT_CNT_EN).
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int N = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    hold,
  regfile_write_arbiter_if.slave  bus,
  output logic [15:0]             conflict_count
);

  logic [1:0]            valid, grant;
  logic [REG_ADDR_W-1:0] sel_addr;
  logic [N-1:0]          sel_data;

  logic                  RegWrite_q, RegWrite_d;
  logic [REG_ADDR_W-1:0] WriteRegister_q, WriteRegister_d;
  logic [N-1:0]          WriteData_q, WriteData_d;

  assign valid = {bus.req1_valid, bus.req0_valid};

  rr_arbiter2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .hold_i  (hold),
    .valid_i (valid),
    .grant_o (grant)
  );

  assign bus.req0_ready = grant[0];
  assign bus.req1_ready = grant[1];

  assign sel_addr = grant[1] ? bus.req1_addr : bus.req0_addr;
  assign sel_data = grant[1] ? bus.req1_data : bus.req0_data;

  // Zero-register writes are consumed but never reach the regfile port,
  // so address/data keep their previous values for that slot.
  always_comb begin
    RegWrite_d      = 1'b0;
    WriteRegister_d = WriteRegister_q;
    WriteData_d     = WriteData_q;
    if ((|grant) && !is_zero_reg(sel_addr)) begin
      RegWrite_d      = 1'b1;
      WriteRegister_d = sel_addr;
      WriteData_d     = sel_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      RegWrite_q      <= 1'b0;
      WriteRegister_q <= '0;
      WriteData_q     <= '0;
    end else begin
      RegWrite_q      <= RegWrite_d;
      WriteRegister_q <= WriteRegister_d;
      WriteData_q     <= WriteData_d;
    end
  end

  assign bus.RegWrite      = RegWrite_q;
  assign bus.WriteRegister = WriteRegister_q;
  assign bus.WriteData     = WriteData_q;

`ifdef REGWR_CONFLICT_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if ((&valid) && !hold && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign conflict_count = cnt_q;
`else
  assign conflict_count = '0;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: directed scenarios then
// random traffic checked against a last-winner reference model.
module tb_regfile_write_arbiter;
  localparam int N = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic        hold;
  logic [15:0] conflict_count;

  regfile_write_arbiter_if #(.N(N)) bus();

  regfile_write_arbiter #(.N(N)) dut (
    .clk            (clk),
    .reset          (reset),
    .hold           (hold),
    .bus            (bus),
    .conflict_count (conflict_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         wr;
    logic [4:0]   addr;
    logic [N-1:0] data;
    logic [15:0]  cnt;
  } exp_t;

  exp_t exp_q[$];
  int   compared = 0;
  int   failed   = 0;

  // reference model state
  int           last_winner = 1;  // requester 0 wins the first tie
  logic [4:0]   m_addr = '0;
  logic [N-1:0] m_data = '0;
  logic [15:0]  m_cnt  = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    compared++;
    if (act !== expv) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // One cycle of stimulus; returns the grants the model says must occur.
  task automatic drive(input logic rst, input logic h,
                       input logic v0, input logic [4:0] a0, input logic [N-1:0] d0,
                       input logic v1, input logic [4:0] a1, input logic [N-1:0] d1,
                       output logic g0, output logic g1);
    exp_t e;
    int   win;
    @(negedge clk);
    reset = rst; hold = h;
    bus.req0_valid = v0; bus.req0_addr = a0; bus.req0_data = d0;
    bus.req1_valid = v1; bus.req1_addr = a1; bus.req1_data = d1;
    #1;
    win = -1;
    if (rst && !h) begin
      if (v0 && v1) win = (last_winner == 1) ? 0 : 1;
      else if (v0)  win = 0;
      else if (v1)  win = 1;
    end
    g0 = (win == 0);
    g1 = (win == 1);
    check("req0_ready", 64'(bus.req0_ready), 64'(g0));
    check("req1_ready", 64'(bus.req1_ready), 64'(g1));
    e.wr = 1'b0;
    if (!rst) begin
      last_winner = 1; m_addr = '0; m_data = '0; m_cnt = '0;
    end else begin
      if (win >= 0) begin
        last_winner = win;
        if ((win == 0 ? a0 : a1) != 5'd0) begin
          e.wr   = 1'b1;
          m_addr = (win == 0) ? a0 : a1;
          m_data = (win == 0) ? d0 : d1;
        end
      end
`ifdef REGWR_CONFLICT_CNT_EN
      if (v0 && v1 && !h && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
`endif
    end
    e.addr = m_addr; e.data = m_data; e.cnt = m_cnt;
    exp_q.push_back(e);
  endtask

  // Monitor: outputs are registered, so compare right after every edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("RegWrite",       64'(bus.RegWrite),      64'(e.wr));
        check("WriteRegister",  64'(bus.WriteRegister), 64'(e.addr));
        check("WriteData",      64'(bus.WriteData),     64'(e.data));
        check("conflict_count", 64'(conflict_count),    64'(e.cnt));
      end
    end
  end

  initial begin
    logic g0, g1;
    logic p0v, p1v;
    logic [4:0] p0a, p1a;
    logic [N-1:0] p0d, p1d;
    logic rst, h;

    reset = 1'b0; hold = 1'b0;
    bus.req0_valid = 1'b0; bus.req0_addr = '0; bus.req0_data = '0;
    bus.req1_valid = 1'b0; bus.req1_addr = '0; bus.req1_data = '0;

    // reset state
    repeat (2) drive(0, 0, 0, 0, 0, 0, 0, 0, g0, g1);
    // single requester, immediate grant, one-cycle latency
    drive(1, 0, 1, 5, 32'hDEADBEEF, 0, 0, 0, g0, g1);
    drive(1, 0, 0, 0, 0, 0, 0, 0, g0, g1);
    // reset then both valid continuously: alternating grants
    drive(0, 0, 0, 0, 0, 0, 0, 0, g0, g1);
    repeat (4) drive(1, 0, 1, 3, 32'h33, 1, 4, 32'h44, g0, g1);
    // zero-register write from requester 1
    drive(1, 0, 0, 0, 0, 1, 0, 32'h1234, g0, g1);
    drive(1, 0, 1, 7, 32'h77, 1, 8, 32'h88, g0, g1);
    // hold for three cycles, then release
    repeat (3) drive(1, 1, 1, 9, 32'h99, 1, 10, 32'hAA, g0, g1);
    repeat (2) drive(1, 0, 1, 9, 32'h99, 1, 10, 32'hAA, g0, g1);
    // reset mid-stream, requester 0 first after release
    drive(1, 0, 1, 11, 32'hB, 1, 12, 32'hC, g0, g1);
    drive(0, 0, 1, 11, 32'hB, 1, 12, 32'hC, g0, g1);
    repeat (3) drive(1, 0, 1, 11, 32'hB, 1, 12, 32'hC, g0, g1);
    // same destination from both
    repeat (2) drive(1, 0, 1, 6, 32'h600, 1, 6, 32'h601, g0, g1);

    // random traffic: requesters hold addr/data until accepted
    p0v = 0; p1v = 0; p0a = '0; p1a = '0; p0d = '0; p1d = '0;
    for (int i = 0; i < 3000; i++) begin
      if (!p0v) begin
        p0v = ($urandom_range(0, 3) != 0);
        p0a = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
        p0d = N'($urandom);
      end
      if (!p1v) begin
        p1v = ($urandom_range(0, 3) != 0);
        p1a = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
        p1d = N'($urandom);
      end
      h   = ($urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 99) != 0);
      drive(rst, h, p0v, p0a, p0d, p1v, p1a, p1d, g0, g1);
      if (!rst) begin
        p0v = 0; p1v = 0;
      end else begin
        if (g0) p0v = 0;
        if (g1) p1v = 0;
      end
    end

    drive(1, 0, 0, 0, 0, 0, 0, 0, g0, g1);
    @(posedge clk);
    #2;
    check("scoreboard_drain", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 Parameter N, default 32, data width of the write port.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset.
REQ-004 hold  input  1  when high, no new grant issued.
REQ-005 req0_valid  input  1  requester 0 (ALU writeback) has a write pending.
REQ-006 req0_addr  input  5  requester 0 destination register.
REQ-007 req0_data  input  N  requester 0 write data.
REQ-008 req0_ready  output  1  requester 0 write consumed this cycle.
REQ-009 req1_valid, req1_addr, req1_data, req1_ready  same widths/directions as REQ-005..008  requester 1 (load writeback).
REQ-010 RegWrite  output  1  registered write enable to register file.
REQ-011 WriteRegister  output  5  registered write address.
REQ-012 WriteData  output  N  registered write data.
REQ-013 conflict_count  output  16  cycles where both requesters were valid and not on hold (REGWR_CONFLICT_CNT_EN only).

Function
REQ-014 Handshake: transfer on reqX_valid & reqX_ready; requester holds addr/data stable while valid and not ready.
REQ-015 reqX_ready combinational: high only for the granted requester, never both in one cycle.
REQ-016 No grant while hold=1; both readies 0, RegWrite 0 next cycle.
REQ-017 Priority FSM, two states: PRIO0 (requester 0 wins ties), PRIO1 (requester 1 wins ties).
REQ-018 Single valid requester granted immediately regardless of FSM state.
REQ-019 After a grant to requester k, FSM moves to priority state of the other requester; no grant -> state unchanged.
REQ-020 Latency: granted write appears on RegWrite/WriteRegister/WriteData exactly one cycle after the transfer cycle.
REQ-021 Address 0 writes: accepted (ready=1, FSM advances) but RegWrite driven 0 for that slot.
REQ-022 RegWrite 0 in any cycle following no transfer; WriteRegister/WriteData hold previous values when RegWrite=0.
REQ-023 Same destination address from both requesters: ordinary arbitration, writes serialized, loser written next eligible cycle.
REQ-024 Maximum waiting time for a valid requester with hold=0: 1 cycle.

Reset
REQ-025 reset=0 at a clock edge: FSM to PRIO0, RegWrite 0, WriteRegister 0, WriteData 0, conflict_count 0.
REQ-026 While reset=0, req0_ready and req1_ready SHALL be 0; a transfer pending at reset assertion is discarded.
REQ-027 First grant possible in the first cycle with reset=1.

Configuration
REQ-028 Macro REGWR_CONFLICT_CNT_EN defined: conflict_count increments by 1 each cycle with req0_valid & req1_valid & ~hold, saturating at 16'hFFFF.
REQ-029 Macro undefined: counter logic absent, conflict_count tied to 0; all other behaviour identical.

Structure
REQ-030 Shared package holds the FSM state typedef (PRIO0, PRIO1), register-address width constant (5) and the zero-register index constant.
REQ-031 One sub-module, rr_arbiter2: 2-way round-robin grant logic plus priority FSM; top holds output register, zero filter, counter.

Verification
REQ-032 Only req0 valid, addr 5, data 32'hDEADBEEF, hold 0 -> req0_ready same cycle; next cycle RegWrite 1, WriteRegister 5, WriteData 32'hDEADBEEF.
REQ-033 Both valid continuously from reset (req0 addr 3, req1 addr 4) -> grants alternate 0,1,0,1; WriteRegister sequence 3,4,3,4; conflict_count 4 after four cycles (macro on).
REQ-034 req1 valid addr 0 data 32'h1234 -> req1_ready 1, next cycle RegWrite 0, FSM in PRIO0.
REQ-035 Both valid with hold=1 for 3 cycles -> no ready, RegWrite 0, conflict_count unchanged; hold drops -> grant per current FSM state.
REQ-036 reset=0 asserted while both valid mid-stream -> next cycle all outputs 0, readies 0; after release, requester 0 granted first.
